cv32e40p_alu_perm_fault_monitor_ft: RTL
=======================================

# cv32e40p_alu_perm_fault_monitor_ft

Parametrised permanent-fault monitor for the replicated ALUs of the fault-tolerant cv32e40p execute stage. It keeps one leaky-bucket error counter per (ALU replica, operation class) pair. Counters increase on detected mismatches and decrease on clean operations. A counter that reaches a threshold sets a sticky permanent-fault flag. The flags feed the voter/reconfiguration logic and the fault CSR, so a damaged sub-unit of one replica can be excluded while its other sub-units stay in use.

## Interface
Parameters:
- N_ALU, 4, number of ALU replicas monitored.
- N_CLASS, 9, number of operation classes: shift/add, logic, bit-manip, bit-count, shuffle, compare, abs/clip, min/max, div/rem.
- CNT_W, 8, counter width in bits.
- THRESHOLD, 100, counter value at which a pair is declared permanently faulty; 1 ≤ THRESHOLD ≤ 2^CNT_W-1.
- ERR_INC, 4, counter increment per detected error; ≥1.
- OK_DEC, 1, counter decrement per clean operation; ≥0 (0 disables leakage).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- alu_enable_i  in  1  an ALU operation completes this cycle.
- class_i  in  $clog2(N_CLASS)  operation class of that operation.
- error_detected_i  in  N_ALU  per-replica mismatch flag for that operation.
- clear_i  in  1  synchronous clear of all counters and flags (software/CSR).
- permanent_fault_o  out  N_ALU*N_CLASS  sticky flags; bit index = alu*N_CLASS + class.
- new_fault_o  out  1  one-cycle pulse when at least one flag rises.
- class_lost_o  out  N_CLASS  registered; bit c is 1 when at least N_ALU-1 replicas have flag c set, meaning voting is no longer possible for class c.
- fault_count_o  out  $clog2(N_ALU*N_CLASS+1)  number of flags currently set.

## Operation
- Each pair (a,c) has counter cnt[a][c] (CNT_W bits, unsigned) and flag flt[a][c].
- An update occurs only when alu_enable_i=1 and class_i<N_CLASS. If class_i≥N_CLASS, the cycle is ignored; no state changes.
- On an update, for each a with flt[a][class_i]=0:
  - error_detected_i[a]=1: cnt ← min(cnt+ERR_INC, 2^CNT_W-1). Compute at CNT_W+1 bits and saturate; no wrap.
  - error_detected_i[a]=0: cnt ← max(cnt-OK_DEC, 0). Floor at 0; no underflow.
- Counters of other classes are not touched.
- Flag set: if the next cnt value is ≥THRESHOLD, flt is set on the same edge. Flags are sticky; only rst_n or clear_i clear them.
- Once flt[a][c]=1, cnt[a][c] is frozen at its current value.
- new_fault_o=1 for exactly the cycle after any edge at which one or more flags transition 0→1. Several flags rising on the same edge produce a single pulse.
- fault_count_o is the population count of permanent_fault_o, registered with the flags (same edge).
- class_lost_o[c] is registered and updated from the flag values of the same edge.

## Timing
- Reset (rst_n=0 at an edge): all cnt=0, all flags=0, new_fault_o=0, class_lost_o=0, fault_count_o=0. Reset is also applied mid-operation with no residual state.
- clear_i has the same effect as reset. It wins over a simultaneous update, so an error in that cycle is discarded.
- Latency: inputs sampled at edge k; counters, flags, fault_count_o and class_lost_o are visible after edge k. new_fault_o is high during cycle k+1 only.
- alu_enable_i=0: all state holds and new_fault_o=0 next cycle.
- All outputs are driven from registers; there are no combinational input-to-output paths.

## Test plan
- Reset then 25 consecutive updates with class_i=3 and error_detected_i=4'b0010 (defaults): cnt[1][3]=96 after 24 updates. After the 25th edge cnt=100, permanent_fault_o bit 12=1, fault_count_o=1, new_fault_o pulses once. A 26th error leaves cnt=100.
- Leakage: alternate errors and clean ops on ALU0 class 0 for 50 updates, giving a net +3 per pair. After 50 updates cnt=75 and no flag. 20 further clean ops bring cnt to 55. 30 clean ops from 10 floor cnt at 0.
- Saturation: CNT_W=4, THRESHOLD=15, ERR_INC=6. Three errors give 6, 12, then 15 (saturated); the flag sets on the third edge.
- Simultaneous faults: drive ALUs 0, 1, 2 to 24 errors on class 8, then one update with error_detected_i=4'b0111. All three flags rise on the same edge, new_fault_o gives a single one-cycle pulse, fault_count_o=3, class_lost_o[8]=1.
- clear_i asserted in the same cycle as an error update: the next state is all zeros and new_fault_o stays 0. rst_n asserted mid-sequence with cnt=57: cnt=0 on the next edge.
- class_i=9 with alu_enable_i=1 and all errors set: no counter changes and no pulse.

Source files
------------

// File: rtl/cv32e40p_alu_perm_fault_monitor_ft.sv
// Permanent-fault monitor for the replicated ALUs: one leaky-bucket error counter
// and one sticky fault flag per (replica, operation class) pair.
module cv32e40p_alu_perm_fault_monitor_ft #(
   parameter int unsigned N_ALU     = 4,
   parameter int unsigned N_CLASS   = 9,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned THRESHOLD = 100,
   parameter int unsigned ERR_INC   = 4,
   parameter int unsigned OK_DEC    = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 alu_enable_i,
   input  logic [$clog2(N_CLASS)-1:0]           class_i,
   input  logic [N_ALU-1:0]                     error_detected_i,
   input  logic                                 clear_i,
   output logic [N_ALU*N_CLASS-1:0]             permanent_fault_o,
   output logic                                 new_fault_o,
   output logic [N_CLASS-1:0]                   class_lost_o,
   output logic [$clog2(N_ALU*N_CLASS+1)-1:0]   fault_count_o
);

   localparam int unsigned      N_PAIR  = N_ALU * N_CLASS;
   localparam int unsigned      FC_W    = $clog2(N_PAIR + 1);
   localparam logic [CNT_W:0]   CNT_MAX = {1'b0, {CNT_W{1'b1}}};
   localparam logic [CNT_W:0]   INC_V   = (CNT_W + 1)'(ERR_INC);
   localparam logic [CNT_W-1:0] DEC_V   = CNT_W'(OK_DEC);
   localparam logic [CNT_W-1:0] THR_V   = CNT_W'(THRESHOLD);

   // Add one error weight, computed one bit wider so the counter saturates instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      logic [CNT_W:0] s;
      s = {1'b0, c} + INC_V;
      if (s > CNT_MAX) begin
         sat_inc = CNT_MAX[CNT_W-1:0];
      end else begin
         sat_inc = s[CNT_W-1:0];
      end
   endfunction

   function automatic logic [CNT_W-1:0] floor_dec(input logic [CNT_W-1:0] c);
      if (c >= DEC_V) begin
         floor_dec = c - DEC_V;
      end else begin
         floor_dec = '0;
      end
   endfunction

   function automatic logic [FC_W-1:0] popcount(input logic [N_PAIR-1:0] v);
      popcount = '0;
      for (int unsigned i = 0; i < N_PAIR; i++) begin
         popcount = popcount + FC_W'(v[i]);
      end
   endfunction

   // A class is lost once voting cannot outvote a faulty replica any more.
   function automatic logic [N_CLASS-1:0] lost_classes(input logic [N_PAIR-1:0] v);
      int n;
      lost_classes = '0;
      for (int unsigned c = 0; c < N_CLASS; c++) begin
         n = 0;
         for (int unsigned a = 0; a < N_ALU; a++) begin
            n = n + int'(v[a*N_CLASS+c]);
         end
         lost_classes[c] = (n >= int'(N_ALU) - 1);
      end
   endfunction

   logic [CNT_W-1:0]   r_cnt       [N_PAIR];
   logic [CNT_W-1:0]   w_cnt_nxt   [N_PAIR];
   logic [N_PAIR-1:0]  r_flt;
   logic [N_PAIR-1:0]  w_flt_nxt;
   logic               w_upd;
   logic               w_rise;
   logic               r_new_fault;
   logic [N_CLASS-1:0] r_class_lost;
   logic [FC_W-1:0]    r_fault_count;

   // Next counter/flag values; flagged pairs keep their counter frozen.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_flt_nxt = r_flt;
      w_upd     = alu_enable_i && (32'(class_i) < N_CLASS);
      for (int unsigned a = 0; a < N_ALU; a++) begin
         for (int unsigned c = 0; c < N_CLASS; c++) begin
            if (w_upd && (32'(class_i) == c) && !r_flt[a*N_CLASS+c]) begin
               if (error_detected_i[a]) begin
                  w_cnt_nxt[a*N_CLASS+c] = sat_inc(r_cnt[a*N_CLASS+c]);
               end else begin
                  w_cnt_nxt[a*N_CLASS+c] = floor_dec(r_cnt[a*N_CLASS+c]);
               end
               if (w_cnt_nxt[a*N_CLASS+c] >= THR_V) begin
                  w_flt_nxt[a*N_CLASS+c] = 1'b1;
               end else begin
                  w_flt_nxt[a*N_CLASS+c] = r_flt[a*N_CLASS+c];
               end
            end else begin
               w_cnt_nxt[a*N_CLASS+c] = r_cnt[a*N_CLASS+c];
               w_flt_nxt[a*N_CLASS+c] = r_flt[a*N_CLASS+c];
            end
         end
      end
      w_rise = |(w_flt_nxt & ~r_flt);
   end

   // State and registered outputs; clear behaves exactly like reset and beats any update.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         for (int unsigned i = 0; i < N_PAIR; i++) begin
            r_cnt[i] <= '0;
         end
         r_flt         <= '0;
         r_new_fault   <= 1'b0;
         r_class_lost  <= '0;
         r_fault_count <= '0;
      end else begin
         r_cnt         <= w_cnt_nxt;
         r_flt         <= w_flt_nxt;
         r_new_fault   <= w_rise;
         r_class_lost  <= lost_classes(w_flt_nxt);
         r_fault_count <= popcount(w_flt_nxt);
      end
   end

   assign permanent_fault_o = r_flt;
   assign new_fault_o       = r_new_fault;
   assign class_lost_o      = r_class_lost;
   assign fault_count_o     = r_fault_count;

endmodule
